// File: rtl/twiddle_w8_sched_pkg.sv
// rtl/twiddle_w8_sched_pkg.sv - shared constants for the odd-twiddle rotation scheduler
package twiddle_w8_sched_pkg;

  // Twiddle select codes carried on req_k
  localparam logic TW_W1 = 1'b0;
  localparam logic TW_W3 = 1'b1;

  // Requester id width on out_id; covers up to four requesters
  localparam int ID_W     = 2;
  localparam int NREQ_MAX = 4;

  // Fixed-point 1/sqrt(2) as 181/256
  localparam int ISQ2_MUL   = 181;
  localparam int ISQ2_SHIFT = 8;

endpackage

// File: rtl/adder_sqrt_2.sv
// rtl/adder_sqrt_2.sv - combinational (a+b)/sqrt2 and (a-b)/sqrt2 at W bits
module adder_sqrt_2 import twiddle_w8_sched_pkg::*; #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] in_1,
  input  logic [2**N-1:0] in_2,
  output logic [2**N-1:0] sum_o,
  output logic [2**N-1:0] diff_o
);

  localparam int W  = 2**N;
  localparam int PW = W + ISQ2_SHIFT + 1;

  // Multiply a sign-extended operand by 181 and floor-divide by 256
  function automatic logic [W-1:0] div_sqrt_2(input logic [W-1:0] x);
    logic [PW-1:0] xe;
    logic [PW-1:0] p;
    xe = {{(PW-W){x[W-1]}}, x};
    p  = xe * PW'(ISQ2_MUL);
    return p[W+ISQ2_SHIFT-1:ISQ2_SHIFT];
  endfunction

  logic [W-1:0] sum_w;
  logic [W-1:0] diff_w;

  // Sums wrap at W bits before scaling
  always_comb begin
    sum_w  = in_1 + in_2;
    diff_w = in_1 - in_2;
    sum_o  = div_sqrt_2(sum_w);
    diff_o = div_sqrt_2(diff_w);
  end

endmodule

// File: rtl/twiddle_w8_sched_arb.sv
// rtl/twiddle_w8_sched_arb.sv - round-robin arbiter, search starts at the pointer
module rr_arbiter import twiddle_w8_sched_pkg::*; #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] id_o,
  output logic            win_o
);

  // First requesting index at or after the pointer, wrapping once
  always_comb begin
    int  idx;
    logic found;
    grant_o = '0;
    id_o    = '0;
    win_o   = 1'b0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en_i && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = ID_W'(idx);
      end
    end
    win_o = found;
  end

endmodule

// File: rtl/twiddle_w8_sched.sv
// rtl/twiddle_w8_sched.sv - shared W8^1/W8^3 rotator with round-robin requesters; TWIDDLE_SCHED_SAT_EN saturates negation
module twiddle_w8_sched import twiddle_w8_sched_pkg::*; #(
  parameter int N    = 3,
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*(2**N)-1:0] req_re,
  input  logic [NREQ*(2**N)-1:0] req_im,
  input  logic [NREQ-1:0]        req_k,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2**N-1:0]        out_re,
  output logic [2**N-1:0]        out_im,
  output logic [ID_W-1:0]        out_id
);

  localparam int W = 2**N;

  // Two's complement negation; the most negative code saturates when enabled
  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
`ifdef TWIDDLE_SCHED_SAT_EN
    if (x == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
`endif
    return -x;
  endfunction

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_re_q, out_re_d;
  logic [W-1:0]    out_im_q, out_im_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            free_w;
  logic            arb_en_w;
  logic [NREQ-1:0] grant_w;
  logic [ID_W-1:0] win_id_w;
  logic            win_w;
  logic [W-1:0]    op_re_w, op_im_w;
  logic            op_k_w;
  logic [W-1:0]    a_w, s_w;

  // Slot accepts when empty or being drained; reset also masks the grant
  assign free_w   = !out_valid_q || out_ready;
  assign arb_en_w = free_w && rst_n;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en_w),
    .grant_o (grant_w),
    .id_o    (win_id_w),
    .win_o   (win_w)
  );

  assign req_ready = grant_w;

  // Operand mux steered by the one-hot grant
  always_comb begin
    op_re_w = '0;
    op_im_w = '0;
    op_k_w  = TW_W1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_w[i]) begin
        op_re_w = req_re[i*W +: W];
        op_im_w = req_im[i*W +: W];
        op_k_w  = req_k[i];
      end
    end
  end

  adder_sqrt_2 #(.N(N)) u_add (
    .in_1   (op_re_w),
    .in_2   (op_im_w),
    .sum_o  (a_w),
    .diff_o (s_w)
  );

  // Next-state for the result slot and round-robin pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (win_w) begin
      out_valid_d = 1'b1;
      out_id_d    = win_id_w;
      if (op_k_w == TW_W1) begin
        out_re_d = a_w;
        out_im_d = neg(s_w);
      end else begin
        out_re_d = neg(s_w);
        out_im_d = neg(a_w);
      end
      ptr_d = (win_id_w == ID_W'(NREQ-1)) ? '0 : win_id_w + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_twiddle_w8_sched.sv
// tb/tb_twiddle_w8_sched.sv - directed bench for twiddle_w8_sched (N=3, NREQ=2)
module tb_twiddle_w8_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_re;
  logic [15:0] req_im;
  logic [1:0]  req_k;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_re;
  logic [7:0]  out_im;
  logic [1:0]  out_id;

  int n_tests;
  int n_fail;

  twiddle_w8_sched #(.N(3), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_re    (req_re),
    .req_im    (req_im),
    .req_k     (req_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int exp_id;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_re    = '0;
    req_im    = '0;
    req_k     = 2'b00;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 16'(out_valid), 16'h0);
    check_eq("rst_req_ready", 16'(req_ready), 16'h0);
    check_eq("rst_out_re",    16'(out_re),    16'h0);
    check_eq("rst_out_im",    16'(out_im),    16'h0);
    check_eq("rst_out_id",    16'(out_id),    16'h0);

    // req0: 4+4j, W8^1 -> (5, 0); req1: 4-4j, W8^3 -> (-5, 0)
    req_re = {8'd4, 8'd4};
    req_im = {8'hFC, 8'd4};
    req_k  = 2'b10;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_eq("first_grant", 16'(req_ready), 16'h1);
        check_eq("first_valid", 16'(out_valid), 16'h0);
      end else begin
        exp_id = (c - 1) % 2;
        check_eq("rr_valid", 16'(out_valid), 16'h1);
        check_eq("rr_id",    16'(out_id),    16'(exp_id));
        check_eq("rr_re",    16'(out_re),    (exp_id == 1) ? 16'hFB : 16'h05);
        check_eq("rr_im",    16'(out_im),    16'h0);
        check_eq("rr_ready", 16'(req_ready), ((c % 2) == 0) ? 16'h1 : 16'h2);
      end
    end

    // Backpressure: slot now holds req1's result
    @(posedge clk); #1 out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("hold_ready", 16'(req_ready), 16'h0);
      check_eq("hold_valid", 16'(out_valid), 16'h1);
      check_eq("hold_id",    16'(out_id),    16'h1);
      check_eq("hold_re",    16'(out_re),    16'hFB);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check_eq("release_ready", 16'(req_ready), 16'h1);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    check_eq("reload_valid", 16'(out_valid), 16'h1);
    check_eq("reload_id",    16'(out_id),    16'h0);
    check_eq("reload_re",    16'(out_re),    16'h05);
    check_eq("idle_ready",   16'(req_ready), 16'h0);

    // Drain with no requester: valid falls, data held
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("drain_valid", 16'(out_valid), 16'h0);
    check_eq("drain_id",    16'(out_id),    16'h0);
    check_eq("drain_re",    16'(out_re),    16'h05);

    // Single request on req1: 10+2j, W8^1 -> a=dsq(12)=8, s=dsq(8)=5 -> (8, -5)
    @(posedge clk); #1;
    req_valid = 2'b10;
    req_re    = {8'd10, 8'd0};
    req_im    = {8'd2, 8'd0};
    req_k     = 2'b00;
    @(negedge clk);
    check_eq("single_ready", 16'(req_ready), 16'h2);
    // Next: -6-6j, W8^3 -> a=dsq(-12)=-9, s=0 -> (0, 9)
    @(posedge clk); #1;
    req_re = {8'hFA, 8'd0};
    req_im = {8'hFA, 8'd0};
    req_k  = 2'b10;
    @(negedge clk);
    check_eq("single_valid", 16'(out_valid), 16'h1);
    check_eq("single_id",    16'(out_id),    16'h1);
    check_eq("single_re",    16'(out_re),    16'h08);
    check_eq("single_im",    16'(out_im),    16'hFB);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("w3_re", 16'(out_re), 16'h00);
    check_eq("w3_im", 16'(out_im), 16'h09);
    check_eq("w3_id", 16'(out_id), 16'h1);

    // Asynchronous reset while the slot is full
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 16'(out_valid), 16'h0);
    check_eq("arst_ready", 16'(req_ready), 16'h0);
    check_eq("arst_re",    16'(out_re),    16'h0);

    #10;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
